// File: rtl/branch_predictor.sv
// branch_predictor: bimodal 2-bit counter predictor with a direct-mapped BTB,
// registered lookup and a registered mispredict/redirect report from the update port.
module branch_predictor #(
    parameter int         IDX_W    = 4,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pred_valid,
    input  logic [31:0] i_pred_pc,
    output logic        o_pred_valid,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic        i_upd_is_branch,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    input  logic        i_flush,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc
);
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q[DEPTH], cnt_d[DEPTH];
    logic [DEPTH-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0] btb_tag_q[DEPTH], btb_tag_d[DEPTH];
    logic [31:0]      btb_target_q[DEPTH], btb_target_d[DEPTH];

    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [IDX_W-1:0] p_idx, u_idx;
    logic [TAG_W-1:0] p_tag, u_tag;
    logic             hit;
    logic             unused_pred_bits;

    assign p_idx = i_pred_pc[IDX_W+1:2];
    assign p_tag = i_pred_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = i_upd_pc[IDX_W+1:2];
    assign u_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pred_bits = ^{i_pred_pc[31:IDX_W+TAG_W+2], i_pred_pc[1:0]};

    // Lookup reads the current (pre-update, pre-flush) state.
    always_comb begin
        hit           = btb_valid_q[p_idx] && (btb_tag_q[p_idx] == p_tag);
        pred_valid_d  = i_pred_valid;
        pred_taken_d  = i_pred_valid && hit && cnt_q[p_idx][1];
        pred_target_d = pred_taken_d ? btb_target_q[p_idx] : 32'd0;
        cnt_d         = cnt_q;
        btb_valid_d   = btb_valid_q;
        btb_tag_d     = btb_tag_q;
        btb_target_d  = btb_target_q;
        if (i_upd_valid) begin
            cnt_d[u_idx] = !i_upd_is_branch ? 2'b11 :
                           i_upd_taken ? ((cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1) :
                                         ((cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1);
            if (i_upd_taken) begin
                btb_valid_d[u_idx]  = 1'b1;
                btb_tag_d[u_idx]    = u_tag;
                btb_target_d[u_idx] = i_upd_target;
            end
        end
        if (i_flush) btb_valid_d = '0;
        mispredict_d  = i_upd_valid && ((i_upd_pred_taken != i_upd_taken) ||
                        (i_upd_taken && (i_upd_pred_target != i_upd_target)));
        redirect_pc_d = !mispredict_d ? 32'd0 : i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]        <= CNT_INIT;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
            btb_valid_q   <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            btb_valid_q   <= btb_valid_d;
            btb_tag_q     <= btb_tag_d;
            btb_target_q  <= btb_target_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_pred_valid  = pred_valid_q;
    assign o_pred_taken  = pred_taken_q;
    assign o_pred_target = pred_target_q;
    assign o_mispredict  = mispredict_q;
    assign o_redirect_pc = redirect_pc_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the execute-stage branch condition evaluator.
- It predicts taken/not-taken and the target for each fetch PC using a bimodal table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- The execute stage writes resolved branch outcomes back through the update port. The block also reports, one cycle later, whether the earlier prediction was wrong, so fetch can redirect.

Parameters:
- IDX_W, 4: index width; table depth = 2**IDX_W entries.
- TAG_W, 8: BTB tag width, taken from PC bits above the index.
- CNT_INIT, 2'b01: counter value after reset (weakly not-taken).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_pred_valid  input  1  fetch lookup request.
- i_pred_pc  input  32  fetch PC to predict.
- o_pred_valid  output  1  registered echo of i_pred_valid.
- o_pred_taken  output  1  predicted taken.
- o_pred_target  output  32  predicted target; 0 when not taken.
- i_upd_valid  input  1  resolved control-flow instruction from execute.
- i_upd_is_branch  input  1  resolved instruction is a conditional branch (1) or an unconditional jump (0).
- i_upd_pc  input  32  PC of the resolved instruction.
- i_upd_taken  input  1  actual outcome (branch-valid result, or 1 for jumps).
- i_upd_target  input  32  actual target.
- i_upd_pred_taken  input  1  prediction that was carried down the pipe.
- i_upd_pred_target  input  32  predicted target that was carried down the pipe.
- i_flush  input  1  invalidate all BTB entries.
- o_mispredict  output  1  registered mispredict pulse.
- o_redirect_pc  output  32  correct next PC when o_mispredict=1, else 0.

Behaviour:
- Indexing:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] is ignored.
- State per entry: cnt[1:0], btb_valid, btb_tag[TAG_W-1:0], btb_target[31:0].
- Reset (asynchronous, active-high):
  - all cnt = CNT_INIT, all btb_valid = 0, btb_tag/btb_target = 0.
  - all outputs = 0.
  - Reset asserted mid-operation discards any in-flight prediction or update; no output glitches past 0.
- Prediction, latency 1 cycle:
  - hit = btb_valid[idx] && btb_tag[idx] == tag(i_pred_pc).
  - Next cycle: o_pred_valid = i_pred_valid; o_pred_taken = i_pred_valid && hit && cnt[idx][1]; o_pred_target = o_pred_taken ? btb_target[idx] : 0.
  - When i_pred_valid=0, all prediction outputs are 0 next cycle.
- Update, when i_upd_valid=1, applied at the clock edge:
  - Conditional branch: cnt[idx] increments if taken (saturates at 2'b11), decrements if not taken (saturates at 2'b00).
  - Jump: cnt[idx] is forced to 2'b11.
  - If i_upd_taken=1: btb_valid=1, btb_tag=tag(i_upd_pc), btb_target=i_upd_target. This overwrites any aliasing entry.
  - If not taken: BTB entry is unchanged.
- Mispredict, registered, 1 cycle after an update:
  - mis = i_upd_valid && ((i_upd_pred_taken != i_upd_taken) || (i_upd_taken && i_upd_pred_target != i_upd_target)).
  - o_mispredict = mis.
  - o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 4. This is 32-bit wrap-around: 0xFFFFFFFC + 4 = 0.
  - When mis=0, o_redirect_pc = 0.
- Simultaneous prediction and update to the same index in one cycle: prediction uses pre-update state (read-before-write). The new state is visible to lookups from the next cycle on.
- Flush:
  - i_flush=1 clears every btb_valid at the edge; counters keep their values.
  - Flush and update in the same cycle: flush wins for BTB valid; the counter update still applies.
  - A prediction issued in the flush cycle uses pre-flush state.

Test Plan:
- Reset, then predict pc=0x00000040 -> next cycle o_pred_valid=1, o_pred_taken=0, o_pred_target=0.
- Branch update pc=0x40, taken, target=0x100, pred_taken=0 -> o_mispredict=1, o_redirect_pc=0x100 next cycle; cnt=2'b10. A later predict of 0x40 -> taken, target 0x100.
- Four taken updates at 0x40 then one not-taken -> cnt saturates at 2'b11, then goes to 2'b10; prediction stays taken. Two further not-taken updates -> 2'b00, prediction not-taken.
- Same-cycle predict and taken update at 0x80 from reset -> that prediction is not-taken; a repeat predict next cycle -> taken.
- Alias test: taken update at 0x40 with target 0x100, then taken update at 0x40+(1<<(IDX_W+2)) with target 0x200 -> predicting 0x40 misses (not-taken); the alias PC predicts 0x200.
- i_flush after training 0x40 -> predict 0x40 is not-taken. Update pc=0xFFFFFFFC not-taken with pred_taken=1 -> o_mispredict=1, o_redirect_pc=0x00000000.
